// File: rtl/sw_evt_pkg.sv
// Shared types and defaults for the switch event capture path.
// Holds the event record layout and the default sizing constants.
package sw_evt_pkg;

    localparam int SW_W_DEF         = 16;
    localparam int TS_W_DEF         = 16;
    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int DROP_W_DEF       = 8;

    typedef struct packed {
        logic [SW_W_DEF-1:0] state;
        logic [SW_W_DEF-1:0] changed;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter, debounced level.
// Ports: clk, reset_i (sync, active high), sw (raw level),
//        deb (debounced level), flip (one-cycle pulse after deb changes).
module sw_debounce_bit
    import sw_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset_i,
    input  logic sw,
    output logic deb,
    output logic flip
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // flip is registered, so it is high in the cycle where deb
    // already shows the new level; the top level loads from that.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta <= 1'b0;
            sync <= 1'b0;
            cnt  <= '0;
            deb  <= 1'b0;
            flip <= 1'b0;
        end else begin
            meta <= sw;
            sync <= meta;
            flip <= 1'b0;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb  <= sync;
                cnt  <= '0;
                flip <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_event_capture.sv
// Debounces the board switches and emits timestamped change records.
// Ports: clk, reset_i, sw_i (raw), evt_valid_o/evt_ready_i (stream),
//        evt_state_o, evt_changed_o, evt_ts_o (record), drop_cnt_o.
module sw_event_capture
    import sw_evt_pkg::*;
#(
    parameter int SW_W         = SW_W_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int TS_W         = TS_W_DEF,
    parameter int DROP_W       = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [SW_W-1:0]   sw_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [SW_W-1:0]   evt_state_o,
    output logic [SW_W-1:0]   evt_changed_o,
    output logic [TS_W-1:0]   evt_ts_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    logic [SW_W-1:0] deb;
    logic [SW_W-1:0] flip;
    logic [TS_W-1:0] ts;
    logic            any_flip;
    logic            accept;
    logic            load;
    logic            drop;

    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_bit (
            .clk    (clk),
            .reset_i(reset_i),
            .sw     (sw_i[i]),
            .deb    (deb[i]),
            .flip   (flip[i])
        );
    end

    assign any_flip = |flip;
    assign accept   = evt_valid_o & evt_ready_i;
    // A slot being emptied this cycle can take the new record directly.
    assign load     = any_flip & (~evt_valid_o | evt_ready_i);
    assign drop     = any_flip & evt_valid_o & ~evt_ready_i;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            evt_valid_o   <= 1'b0;
            evt_state_o   <= '0;
            evt_changed_o <= '0;
            evt_ts_o      <= '0;
        end else if (load) begin
            evt_valid_o   <= 1'b1;
            evt_state_o   <= deb;
            evt_changed_o <= flip;
            evt_ts_o      <= ts;
        end else if (accept) begin
            evt_valid_o   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != {DROP_W{1'b1}})) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_sw_event_capture.sv
// Randomised and directed checks of sw_event_capture against a
// window-based debounce model and an abstract one-slot stream model.
module tb_sw_event_capture;
    import sw_evt_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] sw_i;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [15:0] evt_state_o;
    logic [15:0] evt_changed_o;
    logic [15:0] evt_ts_o;
    logic [7:0]  drop_cnt_o;

    sw_event_capture #(
        .SW_W(16), .DEBOUNCE_CYC(4), .TS_W(16), .DROP_W(8)
    ) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .sw_i         (sw_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_state_o  (evt_state_o),
        .evt_changed_o(evt_changed_o),
        .evt_ts_o     (evt_ts_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: raw samples pass through two stages, then a bit flips once
    // the last four synchronised samples all differ from its level.
    logic [15:0] p1, p2;
    logic [15:0] win [4];
    logic [15:0] deb_m;
    logic [15:0] pend;
    logic        vld_m;
    evt_t        rec_m;
    int          drop_m;
    logic [15:0] n16;

    task automatic model_edge();
        logic [15:0] f;
        logic        acc;
        if (reset_i) begin
            p1 = '0; p2 = '0;
            for (int i = 0; i < 4; i++) win[i] = '0;
            deb_m = '0; pend = '0; vld_m = 1'b0;
            rec_m = '0; drop_m = 0; n16 = '0;
        end else begin
            acc = vld_m && evt_ready_i;
            if (pend != 0 && (!vld_m || acc)) begin
                rec_m.state   = deb_m;
                rec_m.changed = pend;
                rec_m.ts      = n16;
                vld_m = 1'b1;
            end else if (pend != 0) begin
                if (drop_m < 255) drop_m++;
            end else if (acc) begin
                vld_m = 1'b0;
            end
            n16 = n16 + 16'd1;
            for (int i = 3; i > 0; i--) win[i] = win[i-1];
            win[0] = p2;
            p2 = p1;
            p1 = sw_i;
            f = (win[0] ^ deb_m) & (win[1] ^ deb_m)
              & (win[2] ^ deb_m) & (win[3] ^ deb_m);
            deb_m = deb_m ^ f;
            pend  = f;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", evt_valid_o, vld_m);
        chk("drop", drop_cnt_o, drop_m);
        if (vld_m)
            chk("record", {evt_state_o, evt_changed_o, evt_ts_o}, rec_m);
    endtask

    logic [15:0] ts0;
    int          seen;
    int          d0;
    logic [15:0] first_chg;

    initial begin
        reset_i = 1'b1; sw_i = '0; evt_ready_i = 1'b0;
        repeat (3) step();
        chk("rst_valid", evt_valid_o, 0);
        chk("rst_state", evt_state_o, 0);
        chk("rst_ts", evt_ts_o, 0);
        reset_i = 1'b0;

        // idle
        for (int i = 0; i < 50; i++) begin
            evt_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        chk("idle_valid", evt_valid_o, 0);
        chk("idle_drop", drop_cnt_o, 0);

        // clean step: 7-cycle latency, one-cycle record
        evt_ready_i = 1'b1;
        ts0 = n16;
        sw_i = 16'h0005;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k < 7) chk("lat_early", evt_valid_o, 0);
        end
        chk("lat_valid", evt_valid_o, 1);
        chk("lat_state", evt_state_o, 16'h0005);
        chk("lat_chg", evt_changed_o, 16'h0005);
        chk("lat_ts", evt_ts_o, ts0 + 16'd6);
        step();
        chk("lat_drop1", evt_valid_o, 0);

        // 3-cycle glitch then 4-cycle pulse on bit 3
        seen = 0;
        sw_i = 16'h000D;
        repeat (3) step();
        sw_i = 16'h0005;
        for (int i = 0; i < 15; i++) begin
            step();
            if (evt_valid_o) seen++;
        end
        chk("glitch_evts", seen, 0);
        seen = 0;
        first_chg = '0;
        sw_i = 16'h000D;
        repeat (4) step();
        sw_i = 16'h0005;
        for (int i = 0; i < 20; i++) begin
            step();
            if (evt_valid_o) begin
                if (seen == 0) first_chg = evt_changed_o;
                seen++;
            end
        end
        chk("pulse_evts", seen, 2);
        chk("pulse_chg", first_chg, 16'h0008);

        // back-pressure: three changes, first held, two dropped
        evt_ready_i = 1'b0;
        sw_i = sw_i ^ 16'h0002;
        repeat (20) step();
        sw_i = sw_i ^ 16'h0004;
        repeat (20) step();
        sw_i = sw_i ^ 16'h0010;
        repeat (20) step();
        chk("bp_drop", drop_cnt_o, 2);
        chk("bp_chg", evt_changed_o, 16'h0002);
        evt_ready_i = 1'b1;
        step();
        chk("bp_accept", evt_valid_o, 0);

        // saturation then mid-stream reset
        evt_ready_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sw_i = sw_i ^ 16'h0001;
            repeat (6) step();
        end
        repeat (8) step();
        chk("sat_drop", drop_cnt_o, 255);
        sw_i = sw_i ^ 16'h0001;
        repeat (2) step();
        reset_i = 1'b1;
        step();
        chk("mid_rst_drop", drop_cnt_o, 0);
        chk("mid_rst_valid", evt_valid_o, 0);
        reset_i = 1'b0;
        evt_ready_i = 1'b1;
        repeat (15) step();

        // accept and new flip in the same cycle
        evt_ready_i = 1'b0;
        sw_i = sw_i ^ 16'h0020;
        for (int i = 0; i < 20 && !vld_m; i++) step();
        chk("hold_loaded", evt_valid_o, 1);
        sw_i = sw_i ^ 16'h0040;
        for (int i = 0; i < 20 && pend == 0; i++) step();
        chk("hold_flip_seen", pend, 16'h0040);
        d0 = drop_m;
        evt_ready_i = 1'b1;
        step();
        chk("swap_valid", evt_valid_o, 1);
        chk("swap_chg", evt_changed_o, 16'h0040);
        chk("swap_drop", drop_cnt_o, d0);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                sw_i = sw_i ^ (16'h1 << $urandom_range(0, 15));
            evt_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end

        // timestamp wrap
        evt_ready_i = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 70000 && n16 != 16'hFFFA; i++) step();
        chk("wrap_reach", n16, 16'hFFFA);
        sw_i = sw_i ^ 16'h0080;
        repeat (7) step();
        chk("wrap_valid", evt_valid_o, 1);
        chk("wrap_chg", evt_changed_o, 16'h0080);
        chk("wrap_ts", evt_ts_o, 16'h0000);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sw_event_capture.md
Name: sw_event_capture

Overview:
- Input-conditioning stage directly upstream of top_system's logging path.
- Synchronises and debounces the 16 board switches (sw).
- Turns every debounced change into a timestamped event record on a valid/ready stream consumed by the logger.
- Counts events lost to back-pressure so the log can report drops.

Parameters:
SW_W, 16, number of switch inputs
DEBOUNCE_CYC, 4, consecutive differing samples required before a debounced bit flips (>=2)
TS_W, 16, width of free-running timestamp counter
DROP_W, 8, width of saturating drop counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset_i  input  1  synchronous, active-high reset
sw_i  input  SW_W  raw asynchronous switch levels
evt_valid_o  output  1  event record available
evt_ready_i  input  1  downstream accepts record when high with evt_valid_o
evt_state_o  output  SW_W  debounced switch state after the change
evt_changed_o  output  SW_W  mask of bits that flipped in this event
evt_ts_o  output  TS_W  timestamp at the cycle the change was detected
drop_cnt_o  output  DROP_W  saturating count of dropped events

Behaviour:
- Reset (reset_i sampled high at a clk edge):
  - sync flops, debounced state, per-bit counters, timestamp, drop_cnt_o all clear to 0.
  - evt_valid_o=0; evt_state_o, evt_changed_o, evt_ts_o=0.
  - Reset applied mid-operation discards any pending record and any partial debounce count.
- Synchroniser: 2 flops per bit; sync = sw_i delayed 2 cycles.
- Debounce, per bit:
  - If sync==deb, cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYC-1, then deb<=sync and cnt<=0; else cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYC samples restarts the count and produces no flip.
- Latency: a clean sw_i step appears on deb 2+DEBOUNCE_CYC cycles after sw_i changes, and on evt_valid_o one cycle later.
- Flip mask: flip = bits whose deb updates this cycle. All bits flipping in the same cycle form ONE event.
- Timestamp: ts increments every cycle and wraps from 2^TS_W-1 to 0.
- Output slot, single entry, registered:
  - accept = evt_valid_o & evt_ready_i.
  - If flip!=0 and (!evt_valid_o or accept): load slot with state=new deb, changed=flip, ts=current ts; evt_valid_o<=1.
  - Else if flip!=0 and evt_valid_o and !evt_ready_i: event dropped; the slot holds its contents; drop_cnt_o increments, saturating at 2^DROP_W-1 (never wraps).
  - Else if accept: evt_valid_o<=0.
  - A simultaneous accept and new flip loads the new record with no bubble and no drop.
- Stream rules:
  - While evt_valid_o=1 and not accepted, all evt_* outputs are stable.
  - evt_valid_o never depends combinationally on evt_ready_i.
- Debounced state at reset is 0, so switches already high at reset produce a single initial event once debounced.

Decomposition:
- Package sw_evt_pkg:
  - evt_t struct {state, changed, ts}.
  - Default constants SW_W_DEF=16, TS_W_DEF=16, DEBOUNCE_CYC_DEF=4.
- Sub-module sw_debounce_bit:
  - Holds the 2-flop synchroniser, counter and deb flop for one bit.
  - Outputs deb and a flip pulse.
  - Instantiated SW_W times via generate.
- The top level holds the timestamp, output slot and drop counter.

Test Plan:
1. Reset, then sw_i=0x0000 held for 50 cycles -> evt_valid_o stays 0, drop_cnt_o=0.
2. sw_i 0x0000->0x0005 at cycle t with evt_ready_i=1 -> evt_valid_o high at t+7 for one cycle; state=0x0005, changed=0x0005, ts=value at t+6.
3. sw_i bit3 pulses high for 3 cycles (DEBOUNCE_CYC=4) -> no event. A 4-cycle pulse -> rising event (changed=0x0008), followed by a falling event.
4. evt_ready_i=0; three separate single-bit changes spaced 20 cycles apart -> first record held stable, drop_cnt_o=2. Raise evt_ready_i -> record accepted, evt_valid_o=0 next cycle.
5. evt_ready_i=0 with 300 changes -> drop_cnt_o saturates at 255. Assert reset_i mid-stream -> drop_cnt_o=0, evt_valid_o=0 next cycle.
6. Record held (ready=0); in the cycle ready=1 a new flip occurs -> old record accepted, new record valid next cycle, drop_cnt_o unchanged. Also run ts past 0xFFFF and check ts wraps to 0x0000.
